// File: rtl/load_align_pipe.sv
// Load-data aligner/extender with LWL/LWR merge and misalignment flagging, followed by
// a registered output stage plus a one-entry skid buffer.
module load_align_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    localparam int OFF_W = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_addr,
    input  logic [1:0]        in_size,
    input  logic              in_sign,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_old,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_misalign
);

    logic [DATA_W-1:0] w_lane;
    logic [31:0]       w_word;
    logic [31:0]       w_old;
    logic [31:0]       w_merge;
    logic [DATA_W-1:0] w_norm;
    logic [DATA_W-1:0] w_result;
    logic              w_mis;
    logic              w_is_merge;
    logic              w_accept;
    logic              w_retire;
    logic              w_unused;

    logic              r_or_valid;
    logic [DATA_W-1:0] r_or_data;
    logic [TAG_W-1:0]  r_or_tag;
    logic              r_or_mis;
    logic              r_sk_valid;
    logic [DATA_W-1:0] r_sk_data;
    logic [TAG_W-1:0]  r_sk_tag;
    logic              r_sk_mis;

    assign w_lane   = in_data >> {in_addr, 3'b000};
    assign w_old    = in_old[31:0];
    assign w_unused = ^in_old;

    // Merge loads operate on one 32-bit word; on a 64-bit bus addr[2] picks the half.
    generate
        if (DATA_W == 64) begin : g_word64
            assign w_word = in_addr[2] ? in_data[63:32] : in_data[31:0];
        end else begin : g_word32
            assign w_word = in_data[31:0];
        end
    endgenerate

    assign w_is_merge = (in_mode == 2'b01) || (in_mode == 2'b10);

    always_comb begin
        w_merge = w_word;
        if (in_mode == 2'b01) begin
            case (in_addr[1:0])
                2'd0:    w_merge = {w_word[7:0],  w_old[23:0]};
                2'd1:    w_merge = {w_word[15:0], w_old[15:0]};
                2'd2:    w_merge = {w_word[23:0], w_old[7:0]};
                default: w_merge = w_word;
            endcase
        end else begin
            case (in_addr[1:0])
                2'd0:    w_merge = w_word;
                2'd1:    w_merge = {w_old[31:24], w_word[31:8]};
                2'd2:    w_merge = {w_old[31:16], w_word[31:16]};
                default: w_merge = {w_old[31:8],  w_word[31:24]};
            endcase
        end
    end

    always_comb begin
        w_norm = w_lane;
        w_mis  = 1'b0;
        case (in_size)
            2'd0: begin
                w_norm = in_sign ? DATA_W'($signed(w_lane[7:0])) : DATA_W'(w_lane[7:0]);
            end
            2'd1: begin
                w_norm = in_sign ? DATA_W'($signed(w_lane[15:0])) : DATA_W'(w_lane[15:0]);
                w_mis  = in_addr[0];
            end
            2'd2: begin
                w_norm = in_sign ? DATA_W'($signed(w_lane[31:0])) : DATA_W'(w_lane[31:0]);
                w_mis  = (in_addr[1:0] != 2'd0);
            end
            default: begin
                w_norm = w_lane;
                w_mis  = (DATA_W == 32) || (in_addr != '0);
            end
        endcase
        if (w_is_merge) begin
            w_mis = 1'b0;
        end
    end

    always_comb begin
        w_result = w_is_merge ? DATA_W'($signed(w_merge)) : w_norm;
        if (w_mis) begin
            w_result = '0;
        end
    end

    assign in_ready = ~reset & ~r_sk_valid;
    assign w_accept = in_valid & in_ready;
    assign w_retire = r_or_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_or_valid <= 1'b0;
            r_or_data  <= '0;
            r_or_tag   <= '0;
            r_or_mis   <= 1'b0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
            r_sk_tag   <= '0;
            r_sk_mis   <= 1'b0;
        end else begin
            if (w_retire) begin
                if (r_sk_valid) begin
                    r_or_valid <= 1'b1;
                    r_or_data  <= r_sk_data;
                    r_or_tag   <= r_sk_tag;
                    r_or_mis   <= r_sk_mis;
                    r_sk_valid <= 1'b0;
                end else begin
                    r_or_valid <= 1'b0;
                end
            end
            // Accept never coincides with a full skid, so the skid-drain path above can't collide.
            if (w_accept) begin
                if (!r_or_valid || (w_retire && !r_sk_valid)) begin
                    r_or_valid <= 1'b1;
                    r_or_data  <= w_result;
                    r_or_tag   <= in_tag;
                    r_or_mis   <= w_mis;
                end else begin
                    r_sk_valid <= 1'b1;
                    r_sk_data  <= w_result;
                    r_sk_tag   <= in_tag;
                    r_sk_mis   <= w_mis;
                end
            end
        end
    end

    assign out_valid    = r_or_valid;
    assign out_data     = r_or_data;
    assign out_tag      = r_or_tag;
    assign out_misalign = r_or_mis;

endmodule
